// File: rtl/clock_set_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_set_controller_pkg
// Description : Shared mode encodings, field limits/widths and blank-bit
//               indices for the digital-clock time-set sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_set_controller_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } mode_e;

  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned HOUR_MAX = 23;

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;

  localparam int unsigned BLANK_SEC  = 0;
  localparam int unsigned BLANK_MIN  = 1;
  localparam int unsigned BLANK_HOUR = 2;

  // Blank mask for a mode: only the field being edited carries the blink phase.
  function automatic logic [2:0] blank_mask(input mode_e m, input logic phase);
    logic [2:0] mask;
    mask = 3'b000;
    case (m)
      MODE_SET_HOUR: mask[BLANK_HOUR] = phase;
      MODE_SET_MIN:  mask[BLANK_MIN]  = phase;
      MODE_SET_SEC:  mask[BLANK_SEC]  = phase;
      default:       mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clock_set_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_set_controller_if
// Description : Button inputs and display outputs of the clock set
//               controller. master = button/display side, slave = controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface clock_set_controller_if;
  import clock_set_controller_pkg::*;

  logic              btn_mode;
  logic              btn_inc;
  logic              btn_dec;
  logic [SEC_W-1:0]  sec;
  logic [MIN_W-1:0]  min;
  logic [HOUR_W-1:0] hour;
  logic [1:0]        mode;
  logic [2:0]        blank;
  logic              tick_1hz;

  modport master (
    output btn_mode, btn_inc, btn_dec,
    input  sec, min, hour, mode, blank, tick_1hz
  );

  modport slave (
    input  btn_mode, btn_inc, btn_dec,
    output sec, min, hour, mode, blank, tick_1hz
  );

endinterface
`default_nettype wire

// File: rtl/clock_set_controller_wrap_counter.sv
`default_nettype none
// ============================================================================
// Module      : wrap_counter
// Description : Modulo-(MAX+1) up/down counter for one time field. wrap pulses
//               combinationally when a step crosses MAX<->0 so fields chain.
// Revision    : 1.0 - initial release
// ============================================================================
module wrap_counter
  import clock_set_controller_pkg::*;
#(
  parameter int unsigned WIDTH = SEC_W,
  parameter int unsigned MAX   = SEC_MAX
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] value_q, value_d;

  // Next value: a lone inc or dec steps modulo the range; both together hold.
  always_comb begin
    value_d = value_q;
    wrap    = 1'b0;
    if (inc && !dec) begin
      if (value_q == MAX_V) begin
        value_d = '0;
        wrap    = 1'b1;
      end else begin
        value_d = value_q + ONE_V;
      end
    end else if (dec && !inc) begin
      if (value_q == '0) begin
        value_d = MAX_V;
        wrap    = 1'b1;
      end else begin
        value_d = value_q - ONE_V;
      end
    end
  end

  // Field register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) value_q <= '0;
    else          value_q <= value_d;
  end

  assign value = value_q;

endmodule
`default_nettype wire

// File: rtl/clock_set_controller.sv
`default_nettype none
// ============================================================================
// Module      : clock_set_controller
// Description : Hour/minute/second timekeeping with a button-driven set
//               sequence (RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN),
//               2 Hz blink of the edited field and a 1 Hz tick pulse.
//               Optional macro AUTO_REPEAT_EN adds held-button auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_set_controller
  import clock_set_controller_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 1000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  clock_set_controller_if.slave  bus
);

  localparam logic [31:0] PRESC_LAST = 32'(CLK_FREQ_HZ - 1);
  localparam logic [31:0] BLINK_LAST = 32'(CLK_FREQ_HZ / 4 - 1);

  logic              mode_prev_q, mode_prev_d;
  logic              inc_prev_q, inc_prev_d;
  logic              dec_prev_q, dec_prev_d;
  logic              mode_edge, inc_edge, dec_edge;

  mode_e             state_q, state_d;
  logic              sel_hour, sel_min, sel_sec;
  logic              edge_inc_ok, edge_dec_ok;
  logic              rep_inc, rep_dec;
  logic              step_inc, step_dec;

  logic [31:0]       presc_q, presc_d;
  logic [31:0]       blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic              blink_restart;
  logic [2:0]        blank_q, blank_d;
  logic              tick_q, tick_d, tick_now;

  logic              sec_inc, sec_dec, sec_wrap;
  logic              min_inc, min_dec, min_wrap;
  logic              hour_inc, hour_dec, unused_hour_wrap;
  logic [SEC_W-1:0]  sec_val;
  logic [MIN_W-1:0]  min_val;
  logic [HOUR_W-1:0] hour_val;

  // Rising-edge detection against the level seen on the previous clock.
  always_comb begin
    mode_prev_d = bus.btn_mode;
    inc_prev_d  = bus.btn_inc;
    dec_prev_d  = bus.btn_dec;
    mode_edge   = bus.btn_mode & ~mode_prev_q;
    inc_edge    = bus.btn_inc  & ~inc_prev_q;
    dec_edge    = bus.btn_dec  & ~dec_prev_q;
  end

  // Mode state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= MODE_RUN;
    else          state_q <= state_d;
  end

  // Mode sequence: only a mode edge moves the state, always one step forward.
  always_comb begin
    state_d = state_q;
    if (mode_edge) begin
      case (state_q)
        MODE_RUN:      state_d = MODE_SET_HOUR;
        MODE_SET_HOUR: state_d = MODE_SET_MIN;
        MODE_SET_MIN:  state_d = MODE_SET_SEC;
        default:       state_d = MODE_RUN;
      endcase
    end
  end

  // Mode decode: field select and accepted single-button edges in SET states.
  always_comb begin
    sel_hour    = 1'b0;
    sel_min     = 1'b0;
    sel_sec     = 1'b0;
    edge_inc_ok = 1'b0;
    edge_dec_ok = 1'b0;
    case (state_q)
      MODE_SET_HOUR: sel_hour = 1'b1;
      MODE_SET_MIN:  sel_min  = 1'b1;
      MODE_SET_SEC:  sel_sec  = 1'b1;
      default:       sel_hour = 1'b0;
    endcase
    // A mode edge pre-empts inc/dec; simultaneous inc and dec cancel.
    if (state_q != MODE_RUN && !mode_edge) begin
      edge_inc_ok = inc_edge & ~dec_edge;
      edge_dec_ok = dec_edge & ~inc_edge;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [31:0] REP_FIRST = 32'(CLK_FREQ_HZ / 2);
  localparam logic [31:0] REP_NEXT  = 32'(CLK_FREQ_HZ / 2 + CLK_FREQ_HZ / 8);

  logic [31:0] rep_cnt_q, rep_cnt_d, rep_next;
  logic        rep_arm_q, rep_arm_d;

  // Repeat timer: armed by an accepted edge, counts while exactly one button
  // stays held; fires at the half-second mark, then every eighth of a second.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_arm_d = rep_arm_q;
    rep_next  = rep_cnt_q + 32'd1;
    rep_inc   = 1'b0;
    rep_dec   = 1'b0;
    if (state_q == MODE_RUN || mode_edge || (bus.btn_inc == bus.btn_dec)) begin
      rep_cnt_d = '0;
      rep_arm_d = 1'b0;
    end else if (edge_inc_ok || edge_dec_ok) begin
      rep_cnt_d = '0;
      rep_arm_d = 1'b1;
    end else if (rep_arm_q) begin
      rep_cnt_d = rep_next;
      if (rep_next == REP_FIRST || rep_next == REP_NEXT) begin
        rep_inc = bus.btn_inc;
        rep_dec = bus.btn_dec;
      end
      if (rep_next == REP_NEXT) rep_cnt_d = REP_FIRST;
    end
  end

  // Repeat timer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt_q <= '0;
      rep_arm_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_arm_q <= rep_arm_d;
    end
  end
`else
  assign rep_inc = 1'b0;
  assign rep_dec = 1'b0;
`endif

  assign step_inc = edge_inc_ok | rep_inc;
  assign step_dec = edge_dec_ok | rep_dec;

  // Prescaler: free-runs in RUN, parked at 0 in SET and on the way in/out.
  always_comb begin
    tick_now = (state_q == MODE_RUN) && (presc_q == PRESC_LAST);
    if (state_q != MODE_RUN || state_d != MODE_RUN) presc_d = '0;
    else if (presc_q == PRESC_LAST)                 presc_d = '0;
    else                                            presc_d = presc_q + 32'd1;
    tick_d = tick_now;
  end

  // Blink phase: restarts visible on SET entry and on every accepted step.
  always_comb begin
    blink_restart = mode_edge | step_inc | step_dec;
    blink_cnt_d   = blink_cnt_q + 32'd1;
    blink_phase_d = blink_phase_q;
    if (state_d == MODE_RUN || blink_restart) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
    blank_d = blank_mask(state_d, blink_phase_d);
  end

  // Edge, prescaler, blink and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_prev_q   <= 1'b1;
      inc_prev_q    <= 1'b1;
      dec_prev_q    <= 1'b1;
      presc_q       <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      blank_q       <= 3'b000;
      tick_q        <= 1'b0;
    end else begin
      mode_prev_q   <= mode_prev_d;
      inc_prev_q    <= inc_prev_d;
      dec_prev_q    <= dec_prev_d;
      presc_q       <= presc_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      blank_q       <= blank_d;
      tick_q        <= tick_d;
    end
  end

  // Carries only ride on the run-mode tick; SET steps never propagate.
  assign sec_inc  = tick_now | (sel_sec & step_inc);
  assign sec_dec  = sel_sec & step_dec;
  assign min_inc  = (tick_now & sec_wrap) | (sel_min & step_inc);
  assign min_dec  = sel_min & step_dec;
  assign hour_inc = (tick_now & min_wrap) | (sel_hour & step_inc);
  assign hour_dec = sel_hour & step_dec;

  wrap_counter #(.WIDTH(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk(clk), .reset_n(reset_n), .inc(sec_inc), .dec(sec_dec),
    .value(sec_val), .wrap(sec_wrap)
  );

  wrap_counter #(.WIDTH(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk(clk), .reset_n(reset_n), .inc(min_inc), .dec(min_dec),
    .value(min_val), .wrap(min_wrap)
  );

  wrap_counter #(.WIDTH(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk(clk), .reset_n(reset_n), .inc(hour_inc), .dec(hour_dec),
    .value(hour_val), .wrap(unused_hour_wrap)
  );

  assign bus.sec      = sec_val;
  assign bus.min      = min_val;
  assign bus.hour     = hour_val;
  assign bus.mode     = state_q;
  assign bus.blank    = blank_q;
  assign bus.tick_1hz = tick_q;

endmodule
`default_nettype wire

// File: doc/clock_set_controller.md
# clock_set_controller

Timekeeping and time-set sequencer for the digital clock. Holds the hour/minute/second registers, advances them once per second in run mode, and walks the user through setting hour, minute and second with three debounced push-button levels. Its `sec`/`min`/`hour` outputs feed the 7-segment display driver directly. A per-field blank mask blinks the field being edited.

## Interface
- `CLK_FREQ_HZ`, default 1000: `clk` frequency in Hz. Must be ≥ 1000 and divisible by 8.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `btn_mode`  in  1  debounced level; a rising edge advances the mode.
- `btn_inc`  in  1  debounced level; a rising edge increments the selected field.
- `btn_dec`  in  1  debounced level; a rising edge decrements the selected field.
- `sec`  out  6  seconds, 0–59.
- `min`  out  6  minutes, 0–59.
- `hour`  out  5  hours, 0–23.
- `mode`  out  2  0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC.
- `blank`  out  3  bit0 sec, bit1 min, bit2 hour; 1 means the display blanks that field.
- `tick_1hz`  out  1  one-cycle pulse on each run-mode second advance.

## Operation
- **Reset values:** time 00:00:00, `mode`=RUN, `blank`=0, `tick_1hz`=0, prescaler 0, blink phase visible.
- **Edge-detect registers:** reset to 1, so a button held through reset release produces no press.
- **Mode FSM:** a `btn_mode` edge steps RUN→SET_HOUR→SET_MIN→SET_SEC→RUN. There is no other transition.
- **RUN:**
  - The prescaler counts 0..CLK_FREQ_HZ-1. At the terminal count it wraps and the time advances by one second.
  - sec 59→0 carries into min; min 59→0 carries into hour; 23:59:59 → 00:00:00.
  - `btn_inc`/`btn_dec` are ignored.
- **SET_x:**
  - Timekeeping is frozen and the prescaler is held at 0.
  - An inc/dec edge steps only the selected field, modulo its range: 59↔0, 23↔0. It never carries into another field.
- **Return to RUN:** the prescaler restarts from 0, so the first tick occurs a full CLK_FREQ_HZ cycles later.
- **Simultaneous edges:**
  - A mode edge in the same cycle as inc/dec: the mode change wins and the inc/dec is dropped.
  - Inc and dec edges in the same cycle: both are ignored.
- **Blink:**
  - In SET_x, the selected field's `blank` bit toggles every CLK_FREQ_HZ/4 cycles (2 Hz).
  - The phase resets to visible (bit=0) on entering a SET state and on every accepted inc/dec.
  - In RUN, `blank`=0.
- **Arithmetic:** all field math is done at field width. The prescaler and blink counters are 32-bit.

## Timing
- All outputs are registered. No combinational path exists from inputs to outputs.
- **Button:** if the level is 1 at clock edge N and was 0 at edge N-1, the field/mode update is visible after edge N.
- **Tick:**
  - The new time and `tick_1hz`=1 appear together, in the cycle after the prescaler reads CLK_FREQ_HZ-1.
  - The tick period is exactly CLK_FREQ_HZ cycles.
- **Reset mid-operation:**
  - `reset_n` low immediately forces all reset values, regardless of mode or counters.
  - The first press is accepted after the first `clk` edge following `reset_n` deassertion.

## Configuration
- **`AUTO_REPEAT_EN` defined:**
  - In SET_x, an inc or dec held continuously for CLK_FREQ_HZ/2 cycles after its edge generates an additional step.
  - Further steps follow every CLK_FREQ_HZ/8 cycles while the button stays held.
  - Releasing the button, or any mode edge, clears the repeat counter.
  - Holding both inc and dec produces no steps.
- **Undefined:** exactly one step per rising edge. The repeat counter is not built.

## Structure
- **Shared package / constants header:**
  - Mode encodings MODE_RUN, MODE_SET_HOUR, MODE_SET_MIN, MODE_SET_SEC.
  - Field limits SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Blank-bit indices.
- **Sub-module `wrap_counter`:** parameter MAX and WIDTH; inputs inc, dec; output value plus a `wrap` carry pulse. It is instantiated three times, and carries chain through `wrap`.
- The FSM, prescaler, blink and button logic live in the top module.

## Test plan
All scenarios run with CLK_FREQ_HZ=1000.
- **Reset and rollover:** release reset, run 86400×1000 cycles → time passes 23:59:59 then 00:00:00; `tick_1hz` occurs once per 1000 cycles.
- **Mode sequence:** 4 `btn_mode` presses → `mode` reads 1, 2, 3, 0. While in SET states the time stays frozen, then resumes with the first tick 1000 cycles after re-entering RUN.
- **Field wrap:** in SET_HOUR at 23, inc → 0 and min unchanged. In SET_MIN at 0, dec → 59 and hour unchanged.
- **Simultaneous edges:** inc+dec edges in the same cycle → no change. Mode+inc edges in the same cycle → mode advances and the field is unchanged.
- **Blink:** in SET_MIN, `blank`[1] toggles every 250 cycles and `blank`[0]/`blank`[2] stay 0. An inc press → `blank`[1]=0 for the next 250 cycles.
- **Auto-repeat (`AUTO_REPEAT_EN`):** hold inc for 1000 cycles in SET_SEC from 0 → sec=5 (1 edge step + 4 repeats at 500, 625, 750, 875). Without the macro → sec=1.
